// File: rtl/intr_ctrl_if.sv
// Claim/complete and mtimecmp-write bundle between the core's trap handler
// (master) and the interrupt controller (slave).
interface intr_ctrl_if #(
    parameter int ID_W    = 4,
    parameter int TIMER_W = 32
);
    // Handshake: claim_req is a one-cycle request with no ready; the controller
    // always accepts it and answers with claim_valid/claim_id exactly one cycle
    // later. complete_valid and timecmp_we are fire-and-forget strobes.
    logic               claim_req;
    logic               claim_valid;
    logic [ID_W-1:0]    claim_id;
    logic               complete_valid;
    logic [ID_W-1:0]    complete_id;
    logic               timecmp_we;
    logic [TIMER_W-1:0] timecmp_wdata;

    modport master (
        output claim_req, complete_valid, complete_id, timecmp_we, timecmp_wdata,
        input  claim_valid, claim_id
    );

    modport slave (
        input  claim_req, complete_valid, complete_id, timecmp_we, timecmp_wdata,
        output claim_valid, claim_id
    );
endinterface

// File: rtl/intr_ctrl.sv
// Interrupt controller: per-source edge/level gateways, priority arbitration
// with claim/complete tracking, and an mtime/mtimecmp timer.
module intr_ctrl #(
    parameter int NUM_SRC = 8,
    parameter int PRIO_W  = 3,
    parameter int TIMER_W = 32,
    parameter int ID_W    = $clog2(NUM_SRC + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        src_intr,
    input  logic [NUM_SRC-1:0]        src_enable,
    input  logic [NUM_SRC-1:0]        src_edge,
    input  logic [NUM_SRC*PRIO_W-1:0] src_prio,
    input  logic [PRIO_W-1:0]         threshold,
    intr_ctrl_if.slave                bus,
    output logic                      ext_intr,
    output logic                      timer_intr,
    output logic [TIMER_W-1:0]        mtime
);

    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] in_service;
    logic [NUM_SRC-1:0] src_prev;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] claim_mask;
    logic [NUM_SRC-1:0] complete_mask;
    logic [NUM_SRC-1:0] pending_set;
    logic [NUM_SRC-1:0] pending_clr;
    logic [NUM_SRC-1:0] pending_nxt;
    logic [NUM_SRC-1:0] in_service_nxt;
    logic [PRIO_W-1:0]  best_prio;
    logic [ID_W-1:0]    best_id;
    logic [TIMER_W-1:0] mtimecmp;

    always_comb begin : arbiter
        eligible  = '0;
        best_prio = '0;
        best_id   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            eligible[i] = pending[i] & src_enable[i] & ~in_service[i]
                        & (src_prio[i*PRIO_W +: PRIO_W] > threshold);
            // Strict '>' against the running best keeps the lowest index on ties.
            if (eligible[i] && (best_id == '0 || src_prio[i*PRIO_W +: PRIO_W] > best_prio)) begin
                best_prio = src_prio[i*PRIO_W +: PRIO_W];
                best_id   = ID_W'(i + 1);
            end
        end
    end

    always_comb begin : gateway
        claim_mask    = '0;
        complete_mask = '0;
        pending_set   = '0;
        pending_clr   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            claim_mask[i]    = bus.claim_req & (best_id == ID_W'(i + 1));
            complete_mask[i] = bus.complete_valid & (bus.complete_id == ID_W'(i + 1)) & in_service[i];
            pending_set[i]   = src_edge[i] ? (src_intr[i] & ~src_prev[i])
                                           : (src_intr[i] & ~in_service[i]);
            pending_clr[i]   = claim_mask[i] | (~src_edge[i] & ~src_intr[i] & ~in_service[i]);
        end
        // A fresh set beats a claim-clear of the same source in the same cycle.
        pending_nxt    = pending_set | (pending & ~pending_clr);
        in_service_nxt = (in_service & ~complete_mask) | claim_mask;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending         <= '0;
            in_service      <= '0;
            src_prev        <= '0;
            ext_intr        <= 1'b0;
            bus.claim_valid <= 1'b0;
            bus.claim_id    <= '0;
            mtime           <= '0;
            mtimecmp        <= '1;
            timer_intr      <= 1'b0;
        end else begin
            pending         <= pending_nxt;
            in_service      <= in_service_nxt;
            src_prev        <= src_intr;
            ext_intr        <= |eligible;
            bus.claim_valid <= bus.claim_req;
            bus.claim_id    <= bus.claim_req ? best_id : '0;
            mtime           <= mtime + TIMER_W'(1);
            if (bus.timecmp_we) begin
                mtimecmp <= bus.timecmp_wdata;
            end
            timer_intr      <= (mtime >= mtimecmp);
        end
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: directed scenarios plus randomized traffic
// compared against a rule-level reference model.
module tb_intr_ctrl;
    localparam int NUM_SRC = 8;
    localparam int PRIO_W  = 3;
    localparam int TIMER_W = 32;
    localparam int ID_W    = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NUM_SRC-1:0]        src_intr;
    logic [NUM_SRC-1:0]        src_enable;
    logic [NUM_SRC-1:0]        src_edge;
    logic [NUM_SRC*PRIO_W-1:0] src_prio;
    logic [PRIO_W-1:0]         threshold;
    logic                      ext_intr;
    logic                      timer_intr;
    logic [TIMER_W-1:0]        mtime;

    intr_ctrl_if #(.ID_W(ID_W), .TIMER_W(TIMER_W)) bus ();

    intr_ctrl #(
        .NUM_SRC(NUM_SRC), .PRIO_W(PRIO_W), .TIMER_W(TIMER_W), .ID_W(ID_W)
    ) dut (
        .clk(clk), .rst(rst),
        .src_intr(src_intr), .src_enable(src_enable), .src_edge(src_edge),
        .src_prio(src_prio), .threshold(threshold),
        .bus(bus),
        .ext_intr(ext_intr), .timer_intr(timer_intr), .mtime(mtime)
    );

    int checks   = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    logic [NUM_SRC-1:0] m_pend, m_ins, m_prev;
    logic [TIMER_W-1:0] m_mtime, m_cmp;
    logic               m_ext, m_timer, m_cv;
    logic [ID_W-1:0]    m_cid;
    logic [ID_W-1:0]    exp_q[$];

    function automatic int prio_of(int i);
        return int'(src_prio[i*PRIO_W +: PRIO_W]);
    endfunction

    // Scan priority levels from the top down; the first eligible index at a level wins.
    function automatic int model_best();
        for (int p = (1 << PRIO_W) - 1; p > int'(threshold); p--)
            for (int i = 0; i < NUM_SRC; i++)
                if (m_pend[i] && src_enable[i] && !m_ins[i] && prio_of(i) == p)
                    return i + 1;
        return 0;
    endfunction

    task automatic model_reset();
        m_pend = '0; m_ins = '0; m_prev = '0;
        m_mtime = '0; m_cmp = '1;
        m_ext = 1'b0; m_timer = 1'b0; m_cv = 1'b0; m_cid = '0;
    endtask

    // One clock: evaluate the rules on pre-edge state, cross the edge, commit.
    task automatic tick();
        int best;
        logic [NUM_SRC-1:0] np, ni;
        logic n_ext, n_timer, n_cv;
        logic [ID_W-1:0] n_cid;
        logic [TIMER_W-1:0] n_mtime, n_cmp;
        best = model_best();
        np = m_pend;
        ni = m_ins;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (bus.complete_valid && int'(bus.complete_id) == i + 1 && m_ins[i]) ni[i] = 1'b0;
            if (bus.claim_req && best == i + 1) begin np[i] = 1'b0; ni[i] = 1'b1; end
            if (!src_edge[i] && !src_intr[i] && !m_ins[i]) np[i] = 1'b0;
            if (src_edge[i] ? (src_intr[i] && !m_prev[i]) : (src_intr[i] && !m_ins[i])) np[i] = 1'b1;
        end
        n_ext   = (best != 0);
        n_timer = (m_mtime >= m_cmp);
        n_cv    = bus.claim_req;
        n_cid   = bus.claim_req ? ID_W'(best) : '0;
        n_mtime = m_mtime + 1;
        n_cmp   = bus.timecmp_we ? bus.timecmp_wdata : m_cmp;
        if (bus.claim_req) exp_q.push_back(ID_W'(best));
        @(posedge clk);
        #1;
        m_prev = src_intr;
        m_pend = np; m_ins = ni;
        m_ext = n_ext; m_timer = n_timer; m_cv = n_cv; m_cid = n_cid;
        m_mtime = n_mtime; m_cmp = n_cmp;
    endtask

    // ---------------- drivers ----------------
    task automatic set_prio(int i, int p);
        src_prio[i*PRIO_W +: PRIO_W] = PRIO_W'(p);
    endtask

    task automatic drive_idle();
        src_intr = '0; src_enable = '1; src_edge = '1; src_prio = '0; threshold = '0;
        bus.claim_req = 1'b0; bus.complete_valid = 1'b0; bus.complete_id = '0;
        bus.timecmp_we = 1'b0; bus.timecmp_wdata = '0;
    endtask

    task automatic apply_reset();
        #2 rst = 1'b1;
        drive_idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic claim();
        bus.claim_req = 1'b1;
        tick();
        bus.claim_req = 1'b0;
    endtask

    task automatic complete(int id);
        bus.complete_valid = 1'b1;
        bus.complete_id = ID_W'(id);
        tick();
        bus.complete_valid = 1'b0;
        bus.complete_id = '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (ext_intr !== 1'b0) begin failures++; $display("FAIL reset_ext got %b want 0", ext_intr); end
        checks++; if (timer_intr !== 1'b0) begin failures++; $display("FAIL reset_timer got %b want 0", timer_intr); end
        checks++; if (bus.claim_valid !== 1'b0 || bus.claim_id !== '0) begin
            failures++; $display("FAIL reset_claim got v=%b id=%0d want v=0 id=0", bus.claim_valid, bus.claim_id); end
        checks++; if (mtime !== '0) begin failures++; $display("FAIL reset_mtime got %0d want 0", mtime); end
        rst = 1'b0;
        tick();
        checks++; if (mtime !== 32'd1) begin failures++; $display("FAIL reset_mtime_run got %0d want 1", mtime); end
        claim();
        checks++; if (bus.claim_valid !== 1'b1 || bus.claim_id !== 4'd0) begin
            failures++; $display("FAIL reset_claim0 got v=%b id=%0d want v=1 id=0", bus.claim_valid, bus.claim_id); end
    endtask

    task automatic test_edge_single();
        logic seen;
        apply_reset();
        set_prio(2, 5);
        src_intr[2] = 1'b1;
        tick();
        src_intr[2] = 1'b0;
        checks++; if (ext_intr !== 1'b0) begin failures++; $display("FAIL edge_ext_early got %b want 0", ext_intr); end
        tick();
        checks++; if (ext_intr !== 1'b1) begin failures++; $display("FAIL edge_ext_rise got %b want 1", ext_intr); end
        claim();
        checks++; if (bus.claim_valid !== 1'b1 || bus.claim_id !== 4'd3) begin
            failures++; $display("FAIL edge_claim got v=%b id=%0d want v=1 id=3", bus.claim_valid, bus.claim_id); end
        tick();
        checks++; if (ext_intr !== 1'b0 || bus.claim_valid !== 1'b0) begin
            failures++; $display("FAIL edge_after_claim got ext=%b v=%b want ext=0 v=0", ext_intr, bus.claim_valid); end
        complete(3);
        // A new pulse can only reach ext_intr if in_service was cleared.
        src_intr[2] = 1'b1;
        tick();
        src_intr[2] = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 3 && !seen; c++) begin tick(); seen = ext_intr; end
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL edge_complete got ext=%b want 1", seen); end
    endtask

    task automatic test_priority_ties();
        int want [4] = '{2, 5, 7, 0};
        apply_reset();
        set_prio(1, 3); set_prio(4, 3); set_prio(6, 2);
        src_intr = 8'b0101_0010;
        tick();
        src_intr = '0;
        tick();
        checks++; if (ext_intr !== 1'b1) begin failures++; $display("FAIL prio_ext got %b want 1", ext_intr); end
        bus.claim_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (bus.claim_valid !== 1'b1 || int'(bus.claim_id) != want[k]) begin
                failures++; $display("FAIL prio_claim%0d got v=%b id=%0d want v=1 id=%0d", k, bus.claim_valid, bus.claim_id, want[k]); end
        end
        bus.claim_req = 1'b0;
        complete(0); complete(9); complete(3);
        complete(2); complete(5); complete(7);
        claim();
        checks++; if (bus.claim_id !== 4'd0 || ext_intr !== m_ext) begin
            failures++; $display("FAIL prio_drained got id=%0d ext=%b want id=0 ext=%b", bus.claim_id, ext_intr, m_ext); end
    endtask

    task automatic test_level();
        logic seen;
        apply_reset();
        src_edge = 8'b1111_1110;
        set_prio(0, 1);
        src_intr[0] = 1'b1;
        tick(); tick();
        checks++; if (ext_intr !== 1'b1) begin failures++; $display("FAIL level_ext got %b want 1", ext_intr); end
        claim();
        checks++; if (bus.claim_id !== 4'd1) begin failures++; $display("FAIL level_claim1 got %0d want 1", bus.claim_id); end
        tick();
        checks++; if (ext_intr !== 1'b0) begin failures++; $display("FAIL level_in_service got %b want 0", ext_intr); end
        complete(1);
        seen = 1'b0;
        for (int c = 0; c < 2 && !seen; c++) begin tick(); seen = ext_intr; end
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL level_retrigger got %b want 1", seen); end
        claim();
        checks++; if (bus.claim_id !== 4'd1) begin failures++; $display("FAIL level_claim2 got %0d want 1", bus.claim_id); end
        src_intr[0] = 1'b0;
        complete(1);
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++; if (ext_intr !== m_ext) begin failures++; $display("FAIL level_drop%0d got %b want %b", c, ext_intr, m_ext); end
        end
        checks++; if (ext_intr !== 1'b0) begin failures++; $display("FAIL level_settled got %b want 0", ext_intr); end
    endtask

    task automatic test_threshold();
        apply_reset();
        set_prio(3, 4);
        threshold = 3'd4;
        src_intr[3] = 1'b1;
        tick();
        src_intr[3] = 1'b0;
        tick(); tick();
        checks++; if (ext_intr !== 1'b0) begin failures++; $display("FAIL thr_masked got %b want 0", ext_intr); end
        claim();
        checks++; if (bus.claim_id !== 4'd0) begin failures++; $display("FAIL thr_claim0 got %0d want 0", bus.claim_id); end
        threshold = 3'd3;
        tick();
        checks++; if (ext_intr !== 1'b1) begin failures++; $display("FAIL thr_lowered got %b want 1", ext_intr); end
        claim();
        checks++; if (bus.claim_id !== 4'd4) begin failures++; $display("FAIL thr_claim4 got %0d want 4", bus.claim_id); end
        complete(4);
    endtask

    task automatic test_timer();
        int first;
        apply_reset();
        repeat (4) tick();
        bus.timecmp_we = 1'b1; bus.timecmp_wdata = 32'd20;
        tick();
        bus.timecmp_we = 1'b0;
        first = -1;
        for (int c = 0; c < 25; c++) begin
            tick();
            checks++; if (timer_intr !== (m_mtime >= 32'd21)) begin
                failures++; $display("FAIL timer_cmp20 at mtime=%0d got %b want %b", m_mtime, timer_intr, m_mtime >= 32'd21); end
            if (timer_intr === 1'b1 && first < 0) first = int'(m_mtime);
        end
        checks++; if (first != 21) begin failures++; $display("FAIL timer_first got mtime=%0d want 21", first); end
        bus.timecmp_we = 1'b1; bus.timecmp_wdata = 32'd1000;
        tick();
        bus.timecmp_we = 1'b0;
        checks++; if (timer_intr !== 1'b1) begin failures++; $display("FAIL timer_hold got %b want 1", timer_intr); end
        tick();
        checks++; if (timer_intr !== 1'b0) begin failures++; $display("FAIL timer_rewrite got %b want 0", timer_intr); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        set_prio(3, 5); set_prio(1, 3);
        src_intr[3] = 1'b1; tick(); src_intr[3] = 1'b0; tick();
        claim();
        checks++; if (bus.claim_id !== 4'd4) begin failures++; $display("FAIL ares_claim4 got %0d want 4", bus.claim_id); end
        src_intr[1] = 1'b1; tick(); src_intr[1] = 1'b0; tick();
        checks++; if (ext_intr !== 1'b1) begin failures++; $display("FAIL ares_pending got %b want 1", ext_intr); end
        claim();
        #3 rst = 1'b1;
        #1;
        checks++; if (ext_intr !== 1'b0 || timer_intr !== 1'b0 || bus.claim_valid !== 1'b0 ||
                      bus.claim_id !== '0 || mtime !== '0) begin
            failures++; $display("FAIL ares_outputs got ext=%b tmr=%b v=%b id=%0d mtime=%0d want all 0",
                                 ext_intr, timer_intr, bus.claim_valid, bus.claim_id, mtime); end
        drive_idle();
        set_prio(3, 5); set_prio(1, 3);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        claim();
        checks++; if (bus.claim_valid !== 1'b1 || bus.claim_id !== 4'd0) begin
            failures++; $display("FAIL ares_claim0 got v=%b id=%0d want v=1 id=0", bus.claim_valid, bus.claim_id); end
        checks++; if (mtime !== 32'd1) begin failures++; $display("FAIL ares_mtime got %0d want 1", mtime); end
    endtask

    task automatic test_random();
        logic [ID_W-1:0] exp_id;
        apply_reset();
        exp_q.delete();
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) begin
                src_edge   = NUM_SRC'($urandom);
                src_enable = NUM_SRC'($urandom);
                src_prio   = (NUM_SRC*PRIO_W)'($urandom);
                threshold  = PRIO_W'($urandom_range(0, 3));
            end
            src_intr = NUM_SRC'($urandom) & NUM_SRC'($urandom);
            bus.claim_req = ($urandom_range(0, 3) == 0);
            bus.complete_valid = ($urandom_range(0, 2) == 0);
            bus.complete_id = ID_W'($urandom_range(0, 10));
            bus.timecmp_we = ($urandom_range(0, 15) == 0);
            bus.timecmp_wdata = m_mtime + TIMER_W'($urandom_range(0, 40)) - TIMER_W'(12);
            tick();
            checks++; if (ext_intr !== m_ext) begin failures++; $display("FAIL rnd_ext c=%0d got %b want %b", c, ext_intr, m_ext); end
            checks++; if (timer_intr !== m_timer) begin failures++; $display("FAIL rnd_timer c=%0d got %b want %b", c, timer_intr, m_timer); end
            checks++; if (mtime !== m_mtime) begin failures++; $display("FAIL rnd_mtime c=%0d got %0d want %0d", c, mtime, m_mtime); end
            checks++; if (bus.claim_valid !== m_cv) begin failures++; $display("FAIL rnd_cvalid c=%0d got %b want %b", c, bus.claim_valid, m_cv); end
            if (bus.claim_valid === 1'b1 && exp_q.size() > 0) begin
                exp_id = exp_q.pop_front();
                checks++; if (bus.claim_id !== exp_id) begin
                    failures++; $display("FAIL rnd_claim_id c=%0d got %0d want %0d", c, bus.claim_id, exp_id); end
            end
        end
        drive_idle();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        drive_idle();
        test_reset();
        test_edge_single();
        test_priority_ties();
        test_level();
        test_threshold();
        test_timer();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
Parametrised interrupt controller that drives the core's external and timer interrupt inputs. It replaces the fixed single ext_intr/timer_intr stimulus with the following:
- NUM_SRC sources, each configurable as edge- or level-triggered, with a per-source enable and priority.
- A claim/complete handshake with the core's trap handler.
- A built-in mtime/mtimecmp timer.

It sits between external interrupt sources and core.ext_intr / core.timer_intr.

Parameters:
NUM_SRC, 8, number of external interrupt sources (1..31)
PRIO_W, 3, priority field width; priority 0 means never interrupt
TIMER_W, 32, width of mtime and mtimecmp
ID_W, $clog2(NUM_SRC+1), claim/complete ID width; ID 0 = none, source i has ID i+1

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
src_intr  in  NUM_SRC  raw source lines, synchronous to clk
src_enable  in  NUM_SRC  per-source arbitration enable
src_edge  in  NUM_SRC  1 = rising-edge triggered, 0 = level triggered
src_prio  in  NUM_SRC*PRIO_W  priority of source i in bits [i*PRIO_W +: PRIO_W]
threshold  in  PRIO_W  only priorities strictly greater than this interrupt
claim_req  in  1  single-cycle claim request
claim_valid  out  1  claim response strobe
claim_id  out  ID_W  claimed ID (0 = nothing eligible)
complete_valid  in  1  completion strobe
complete_id  in  ID_W  ID being completed
timecmp_we  in  1  write strobe for mtimecmp
timecmp_wdata  in  TIMER_W  new mtimecmp value
ext_intr  out  1  registered external interrupt request to the core
timer_intr  out  1  registered timer interrupt request to the core
mtime  out  TIMER_W  free-running time counter

Behaviour:
- Reset (asynchronous, all at once):
  - pending, in_service and src_prev are all 0.
  - claim_valid = 0, claim_id = 0, ext_intr = 0, timer_intr = 0.
  - mtime = 0, mtimecmp = all ones.
- Edge source:
  - pending[i] sets when src_intr[i] & ~src_prev[i].
  - A new edge while in service is latched, one deep; further edges while already pending are lost.
- Level source:
  - pending[i] sets when src_intr[i] & ~in_service[i].
  - pending[i] clears when src_intr drops while unclaimed.
- Pending is independent of src_enable; the enable only masks arbitration.
- Eligible set: pending & enable & (prio > threshold) & ~in_service.
- Winner: highest prio; ties go to the lowest index; best_id = index+1, or 0 if nothing is eligible.
- ext_intr is registered: ext_intr <= (eligible set != 0).
  - Latency: src sampled high at edge k -> pending after k -> ext_intr after k+1.
- Claim:
  - claim_req sampled at edge k -> claim_valid = 1 for exactly one cycle after edge k.
  - claim_id = best_id as computed from state before edge k.
  - If best_id != 0, the same edge clears pending[best_id-1] and sets in_service[best_id-1].
  - If best_id = 0, no state change.
  - claim_req held multiple cycles means one claim per cycle.
- Complete:
  - complete_valid with in_service[complete_id-1] = 1 clears that bit.
  - complete_id of 0, > NUM_SRC, or not in service is ignored.
- Simultaneous events:
  - Pending set and claim-clear of the same source in one cycle: set wins, so pending stays 1.
  - Claim and complete in the same cycle are both applied.
  - Complete and level re-trigger of the same source: pending sets one cycle after in_service clears.
- Config changes (enable/prio/threshold) take effect on the next ext_intr update; there is no stale hold.
- Timer:
  - mtime increments every cycle and wraps from all-ones to 0.
  - timecmp_we at edge k loads mtimecmp.
  - timer_intr <= (mtime >= mtimecmp) is unsigned and registered, so it reflects the new mtimecmp after edge k+1.
  - timer_intr stays high until mtimecmp is rewritten above mtime or mtime wraps.
- Reset asserted mid-claim or mid-service returns the block to the reset state immediately; the next claim returns ID 0.

Test Plan:
1. Reset, then edge src 2 (prio 5, threshold 0, enabled) pulses 1 cycle -> ext_intr high 2 cycles later; claim_req -> claim_valid next cycle with claim_id = 3; ext_intr falls; complete_id = 3 clears in_service.
2. Edge src 1 (prio 3) and src 4 (prio 3) rise together, plus src 6 (prio 2) -> first claim returns ID 2, second returns ID 5, third returns ID 7, fourth returns ID 0.
3. Level src 0 is held high through claim and complete -> claim returns ID 1; after complete, pending re-sets and ext_intr reasserts within 2 cycles; a second claim returns ID 1.
4. Threshold = 4 with src prio 4 pending -> ext_intr stays 0 and claim returns ID 0; set threshold = 3 -> ext_intr = 1 on the next cycle.
5. Write mtimecmp = 20 at reset+5 -> timer_intr = 0 until mtime = 20, then timer_intr = 1 one cycle later; write mtimecmp = 1000 -> timer_intr = 0 after 1 cycle.
6. Assert rst while in_service[3] = 1 and pending is nonzero -> all outputs return to reset values asynchronously; the claim after release returns ID 0 and mtime restarts at 0.
